// File: rtl/mvp_sequencer_if.sv
// Operand/result bus between the MVP sequencer and its shared mat_mul instance.
// The master modport is the sequencer side; the slave modport is the multiplier side.
interface mvp_sequencer_if #(
  parameter int unsigned DATAWIDTH = 18
);
  logic signed [DATAWIDTH-1:0] mm_A [4][4];
  logic signed [DATAWIDTH-1:0] mm_B [4][4];
  logic                        mm_i_dv;
  logic signed [DATAWIDTH-1:0] mm_C [4][4];
  logic                        mm_o_dv;
  logic                        mm_o_ready;

  modport master (
    output mm_A,
    output mm_B,
    output mm_i_dv,
    input  mm_C,
    input  mm_o_dv,
    input  mm_o_ready
  );

  modport slave (
    input  mm_A,
    input  mm_B,
    input  mm_i_dv,
    output mm_C,
    output mm_o_dv,
    output mm_o_ready
  );
endinterface

// File: rtl/mvp_sequencer.sv
// Builds MVP = P*V*M on one shared mat_mul: PV = P*V, then MVP = PV*M.
// PV is cached so model-only updates take a single multiply; a watchdog flags a stalled multiplier.
module mvp_sequencer #(
  parameter int unsigned DATAWIDTH      = 18,
  parameter int unsigned FRACBITS       = 12,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic signed [DATAWIDTH-1:0] P [4][4],
  input  logic signed [DATAWIDTH-1:0] V [4][4],
  input  logic signed [DATAWIDTH-1:0] M [4][4],
  input  logic                        i_reuse_pv,
  input  logic                        i_dv,
  input  logic                        i_err_clr,
  output logic signed [DATAWIDTH-1:0] MVP [4][4],
  output logic                        o_dv,
  output logic                        o_ready,
  output logic                        o_pv_valid,
  output logic                        o_err,
  mvp_sequencer_if.master             mm
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TimerW-1:0] TimeoutLast = TimerW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StIssuePv  = 3'd1;
  localparam logic [2:0] StWaitPv   = 3'd2;
  localparam logic [2:0] StIssueMvp = 3'd3;
  localparam logic [2:0] StWaitMvp  = 3'd4;
  localparam logic [2:0] StError    = 3'd5;

  // Fixed-point format is only meaningful if there is at least one integer bit.
  if (FRACBITS >= DATAWIDTH) begin : g_fracbits_check
    $error("FRACBITS must be smaller than DATAWIDTH");
  end

  typedef logic signed [DATAWIDTH-1:0] mat_t [4][4];

  logic [2:0]        state_q, state_d;
  mat_t              p_q, p_d, v_q, v_d, m_q, m_d;
  mat_t              pv_q, pv_d, mvp_q, mvp_d;
  logic              dv_q, dv_d;
  logic              ready_q, ready_d;
  logic              pv_valid_q, pv_valid_d;
  logic              err_q, err_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              wd_expired;

  assign wd_expired = (timer_q == TimeoutLast);

  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    v_d        = v_q;
    m_d        = m_q;
    pv_d       = pv_q;
    mvp_d      = mvp_q;
    dv_d       = 1'b0;
    ready_d    = ready_q;
    pv_valid_d = pv_valid_q;
    err_d      = err_q;
    timer_d    = timer_q;

    case (state_q)
      StIdle: begin
        if (i_dv && ready_q) begin
          p_d     = P;
          v_d     = V;
          m_d     = M;
          ready_d = 1'b0;
          state_d = (i_reuse_pv && pv_valid_q) ? StIssueMvp : StIssuePv;
        end
      end
      StIssuePv: begin
        if (mm.mm_o_ready) begin
          state_d = StWaitPv;
          timer_d = '0;
        end
      end
      StWaitPv: begin
        // Result is only present in the mm_o_dv cycle; mat_mul clears C afterwards.
        if (mm.mm_o_dv) begin
          pv_d       = mm.mm_C;
          pv_valid_d = 1'b1;
          state_d    = StIssueMvp;
        end else if (wd_expired) begin
          state_d    = StError;
          err_d      = 1'b1;
          pv_valid_d = 1'b0;
          pv_d       = '{default: '0};
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StIssueMvp: begin
        if (mm.mm_o_ready) begin
          state_d = StWaitMvp;
          timer_d = '0;
        end
      end
      StWaitMvp: begin
        if (mm.mm_o_dv) begin
          mvp_d   = mm.mm_C;
          dv_d    = 1'b1;
          ready_d = 1'b1;
          state_d = StIdle;
        end else if (wd_expired) begin
          state_d    = StError;
          err_d      = 1'b1;
          pv_valid_d = 1'b0;
          pv_d       = '{default: '0};
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StError: begin
        if (i_err_clr) begin
          err_d   = 1'b0;
          ready_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      p_q        <= '{default: '0};
      v_q        <= '{default: '0};
      m_q        <= '{default: '0};
      pv_q       <= '{default: '0};
      mvp_q      <= '{default: '0};
      dv_q       <= 1'b0;
      ready_q    <= 1'b1;
      pv_valid_q <= 1'b0;
      err_q      <= 1'b0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      v_q        <= v_d;
      m_q        <= m_d;
      pv_q       <= pv_d;
      mvp_q      <= mvp_d;
      dv_q       <= dv_d;
      ready_q    <= ready_d;
      pv_valid_q <= pv_valid_d;
      err_q      <= err_d;
      timer_q    <= timer_d;
    end
  end

  // Moore request: one mm_i_dv pulse per multiply, operands held for the whole ISSUE state.
  always_comb begin
    mm.mm_i_dv = (state_q == StIssuePv) || (state_q == StIssueMvp);
    mm.mm_A    = pv_q;
    mm.mm_B    = m_q;
    if (state_q == StIssuePv) begin
      mm.mm_A = p_q;
      mm.mm_B = v_q;
    end
  end

  assign MVP        = mvp_q;
  assign o_dv       = dv_q;
  assign o_ready    = ready_q;
  assign o_pv_valid = pv_valid_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_mvp_sequencer.sv
// Self-checking bench for mvp_sequencer with a behavioural 7-cycle mat_mul stand-in.
// Expected results are queued at request time and popped when o_dv fires.
module tb_mvp_sequencer;

  localparam int DW  = 18;
  localparam int One = 4096;

  typedef logic signed [DW-1:0] mat_t [4][4];
  typedef struct {
    logic [287:0] mvp;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  mat_t P, V, M, MVP;
  logic i_reuse_pv, i_dv, i_err_clr;
  logic o_dv, o_ready, o_pv_valid, o_err;
  bit   mm_hang;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   acc_cyc = 0;
  int   hs_cnt  = 0;
  int   dv_cnt  = 0;
  exp_t exp_q[$];

  logic [287:0] mm_res;
  logic         mm_busy;
  int           mm_cnt;

  mvp_sequencer_if #(.DATAWIDTH(DW)) mm_bus ();

  mvp_sequencer #(
    .DATAWIDTH     (DW),
    .FRACBITS      (12),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .P         (P),
    .V         (V),
    .M         (M),
    .i_reuse_pv(i_reuse_pv),
    .i_dv      (i_dv),
    .i_err_clr (i_err_clr),
    .MVP       (MVP),
    .o_dv      (o_dv),
    .o_ready   (o_ready),
    .o_pv_valid(o_pv_valid),
    .o_err     (o_err),
    .mm        (mm_bus)
  );

  always #5 clk = ~clk;

  function automatic logic [287:0] flat(input mat_t m);
    logic [287:0] r;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        r[(i*4+j)*DW +: DW] = m[i][j];
    return r;
  endfunction

  function automatic logic [287:0] diag(input int a, input int b, input int c, input int d);
    logic [287:0] r;
    r = '0;
    r[0*DW +: DW]  = DW'(a);
    r[5*DW +: DW]  = DW'(b);
    r[10*DW +: DW] = DW'(c);
    r[15*DW +: DW] = DW'(d);
    return r;
  endfunction

  function automatic logic [287:0] mmul(input logic [287:0] a, input logic [287:0] b);
    logic [287:0] r;
    longint       acc;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        acc = 0;
        for (int k = 0; k < 4; k++)
          acc += longint'($signed(a[(i*4+k)*DW +: DW])) * longint'($signed(b[(k*4+j)*DW +: DW]));
        r[(i*4+j)*DW +: DW] = DW'(acc >>> 12);
      end
    return r;
  endfunction

  task automatic check(input string tag, input logic [287:0] got, input logic [287:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mat_mul stand-in: handshake edge -> mm_o_dv sampled 7 edges later, C zeroed after.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mm_busy           <= 1'b0;
      mm_cnt            <= 0;
      mm_res            <= '0;
      mm_bus.mm_o_dv    <= 1'b0;
      mm_bus.mm_o_ready <= 1'b1;
      mm_bus.mm_C       <= '{default: '0};
    end else if (mm_busy) begin
      if (mm_cnt == 1) begin
        mm_bus.mm_o_dv <= 1'b1;
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++)
            mm_bus.mm_C[i][j] <= mm_res[(i*4+j)*DW +: DW];
        mm_cnt <= 0;
      end else if (mm_cnt == 0) begin
        mm_bus.mm_o_dv    <= 1'b0;
        mm_bus.mm_C       <= '{default: '0};
        mm_busy           <= 1'b0;
        mm_bus.mm_o_ready <= 1'b1;
      end else begin
        mm_cnt <= mm_cnt - 1;
      end
    end else if (mm_bus.mm_i_dv && mm_bus.mm_o_ready && !mm_hang) begin
      mm_res            <= mmul(flat(mm_bus.mm_A), flat(mm_bus.mm_B));
      mm_busy           <= 1'b1;
      mm_cnt            <= 6;
      mm_bus.mm_o_ready <= 1'b0;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rstn && i_dv && o_ready) acc_cyc <= cyc + 1;
    if (rstn && mm_bus.mm_i_dv) hs_cnt <= hs_cnt + 1;
  end

  // Scoreboard: every o_dv pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_dv === 1'b1) begin
        dv_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_dv", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("mvp", flat(MVP), e.mvp);
          check("latency", cyc - acc_cyc, e.lat);
        end
      end
    end
  end

  task automatic drive(input logic [287:0] pf, input logic [287:0] vf, input logic [287:0] mf);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        P[i][j] = pf[(i*4+j)*DW +: DW];
        V[i][j] = vf[(i*4+j)*DW +: DW];
        M[i][j] = mf[(i*4+j)*DW +: DW];
      end
  endtask

  task automatic run_req(input logic [287:0] pf, input logic [287:0] vf, input logic [287:0] mf,
                         input logic reuse, input logic [287:0] expf, input int lat,
                         input int hs, input bit poke);
    int h0, d0;
    for (int n = 0; n < 200 && o_ready !== 1'b1; n++) @(negedge clk);
    if (o_ready !== 1'b1) check("ready_timeout", o_ready, 1);
    h0 = hs_cnt;
    d0 = dv_cnt;
    drive(pf, vf, mf);
    i_reuse_pv = reuse;
    i_dv       = 1'b1;
    exp_q.push_back('{mvp: expf, lat: lat});
    @(negedge clk);
    i_dv       = 1'b0;
    i_reuse_pv = 1'b0;
    if (poke) begin
      repeat (3) @(negedge clk);
      drive(diag(2*One, 2*One, 2*One, 2*One), vf, mf);
      i_dv = 1'b1;
      @(negedge clk);
      i_dv = 1'b0;
    end
    for (int n = 0; n < 100 && dv_cnt == d0; n++) @(negedge clk);
    if (dv_cnt == d0) begin
      check("dv_timeout", 0, 1);
      exp_q.delete();
    end
    check("mm_pulses", hs_cnt - h0, hs);
    if (poke) begin
      repeat (20) @(negedge clk);
      check("single_dv", dv_cnt - d0, 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [287:0] id, pm, vm, z;
    int           d0;
    id = diag(One, One, One, One);
    z  = '0;

    rstn       = 1'b0;
    i_dv       = 1'b0;
    i_reuse_pv = 1'b0;
    i_err_clr  = 1'b0;
    mm_hang    = 1'b0;
    drive(z, z, z);
    repeat (3) @(negedge clk);
    check("rst_ready", o_ready, 1);
    check("rst_dv", o_dv, 0);
    check("rst_pv_valid", o_pv_valid, 0);
    check("rst_err", o_err, 0);
    check("rst_mm_i_dv", mm_bus.mm_i_dv, 0);
    check("rst_mvp", flat(MVP), z);
    rstn = 1'b1;
    @(negedge clk);

    // Reuse requested with no cached PV: full path.
    run_req(id, id, id, 1'b1, id, 16, 2, 1'b0);
    check("pv_valid_set", o_pv_valid, 1);

    run_req(id, id, id, 1'b0, id, 16, 2, 1'b0);

    run_req(diag(2*One, 2*One, 2*One, 2*One), diag(3*One, 3*One, 3*One, 3*One),
            diag(One/2, One/2, One/2, One/2), 1'b0,
            diag(3*One, 3*One, 3*One, 3*One), 16, 2, 1'b0);
    // P and V zero: only the cached PV can give 6I.
    run_req(z, z, id, 1'b1, diag(6*One, 6*One, 6*One, 6*One), 8, 1, 1'b0);

    pm = id;
    pm[3*DW +: DW] = DW'(One);
    vm = diag(2*One, 2*One, 2*One, One);
    run_req(pm, vm, id, 1'b0, mmul(mmul(pm, vm), id), 16, 2, 1'b0);
    check("order_03", MVP[0][3], One);
    check("order_00", MVP[0][0], 2*One);

    // Second i_dv while busy must be dropped.
    run_req(id, id, id, 1'b0, id, 16, 2, 1'b1);

    // Stalled multiplier.
    mm_hang = 1'b1;
    drive(id, id, id);
    i_dv = 1'b1;
    @(negedge clk);
    i_dv = 1'b0;
    for (int n = 0; n < 120 && o_err !== 1'b1; n++) @(negedge clk);
    check("err_latency", cyc - acc_cyc, 65);
    check("err_set", o_err, 1);
    check("err_ready", o_ready, 0);
    check("err_pv_valid", o_pv_valid, 0);
    i_dv = 1'b1;
    @(negedge clk);
    i_dv = 1'b0;
    @(negedge clk);
    check("err_ignores_dv", o_err, 1);
    check("err_ready_held", o_ready, 0);
    i_err_clr = 1'b1;
    @(negedge clk);
    i_err_clr = 1'b0;
    check("err_clr", o_err, 0);
    check("err_clr_ready", o_ready, 1);
    mm_hang = 1'b0;
    run_req(id, id, id, 1'b1, id, 16, 2, 1'b0);

    // Reset during WAIT_MVP abandons the job.
    drive(id, id, id);
    i_dv = 1'b1;
    exp_q.push_back('{mvp: id, lat: 16});
    @(negedge clk);
    i_dv = 1'b0;
    repeat (11) @(negedge clk);
    d0   = dv_cnt;
    rstn = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_ready", o_ready, 1);
    check("mid_rst_dv", o_dv, 0);
    check("mid_rst_pv_valid", o_pv_valid, 0);
    check("mid_rst_mm_i_dv", mm_bus.mm_i_dv, 0);
    check("mid_rst_mvp", flat(MVP), z);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    check("no_dv_after_rst", dv_cnt - d0, 0);
    run_req(id, id, id, 1'b0, id, 16, 2, 1'b0);

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
